// File: rtl/mips32_loader_pkg.sv
// Shared definitions for the MIPS32 program loader: FSM state encoding,
// word/byte geometry.
package mips32_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mips32_loader_assembler.sv
// Byte-to-word assembler for the program loader: big-endian shift register,
// byte index within the current word and running mod-256 checksum.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart a load (index and checksum to zero)
//   shift_en   : accept data as the next byte of the stream
//   data       : incoming byte
//   word_c     : word as it will be after shifting in data (combinational)
//   last_c     : data completes the current word (combinational)
//   sum        : checksum of all bytes shifted in since clear
module mips32_loader_assembler
    import mips32_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word_c,
    output logic              last_c,
    output logic [BYTE_W-1:0] sum
);

    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;

    // First byte ends up in bits 31:24 after four shifts.
    assign word_c = {word_q[WORD_W-BYTE_W-1:0], data};
    assign last_c = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    // Index wraps naturally after the fourth byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
            sum    <= '0;
        end else if (clear) begin
            word_q <= '0;
            idx_q  <= '0;
            sum    <= '0;
        end else if (shift_en) begin
            word_q <= word_c;
            idx_q  <= idx_q + IDX_W'(1);
            sum    <= sum + data;
        end
    end

endmodule

// File: rtl/mips32_program_loader.sv
// Run-time instruction-memory loader for the single-cycle MIPS32 core.
// Receives a byte stream, writes big-endian words to consecutive addresses,
// verifies a trailing checksum byte and stalls the CPU while loading.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : begin a load (honoured in IDLE/DONE only)
//   base_addr, word_count : load geometry, latched on start
//   in_valid, in_data     : byte stream; in_ready accepts (decoded from state)
//   mem_we/addr/wdata     : instruction-memory write port, one pulse per word
//   cpu_hold, busy        : high for the whole load
//   done                  : one-cycle pulse after the checksum byte
//   error                 : checksum mismatch, held until the next start
module mips32_program_loader
    import mips32_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_q, addr_nxt;
    logic [CNT_W-1:0]   remain_q, remain_nxt;
    logic               mem_we_nxt, busy_nxt, done_nxt, error_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [WORD_W-1:0]  mem_wdata_nxt;
    logic               hs_c, asm_clear_c, asm_shift_c, last_c;
    logic [WORD_W-1:0]  word_c;
    logic [BYTE_W-1:0]  sum;

    assign in_ready = (state == RECV) || (state == CHECK);
    assign hs_c     = in_valid & in_ready;

    mips32_loader_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (asm_clear_c),
        .shift_en (asm_shift_c),
        .data     (in_data),
        .word_c   (word_c),
        .last_c   (last_c),
        .sum      (sum)
    );

    // Next state and next registered outputs; write port is loaded on the
    // transition into WRITE so it is valid during the WRITE cycle.
    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr_q;
        remain_nxt    = remain_q;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        done_nxt      = 1'b0;
        error_nxt     = error;
        asm_clear_c   = 1'b0;
        asm_shift_c   = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    addr_nxt    = base_addr;
                    remain_nxt  = word_count;
                    asm_clear_c = 1'b1;
                    error_nxt   = 1'b0;
                    state_nxt   = (word_count != '0) ? RECV : CHECK;
                end
            end
            RECV: begin
                if (hs_c) begin
                    asm_shift_c = 1'b1;
                    if (last_c) begin
                        state_nxt     = WRITE;
                        mem_we_nxt    = 1'b1;
                        mem_addr_nxt  = addr_q;
                        mem_wdata_nxt = word_c;
                    end
                end
            end
            WRITE: begin
                addr_nxt   = addr_q + ADDR_W'(1);
                remain_nxt = remain_q - CNT_W'(1);
                state_nxt  = (remain_q != CNT_W'(1)) ? RECV : CHECK;
            end
            CHECK: begin
                if (hs_c) begin
                    error_nxt = (in_data != sum);
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == RECV) || (state_nxt == WRITE) || (state_nxt == CHECK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            remain_q  <= remain_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            cpu_hold  <= busy_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            error     <= error_nxt;
        end
    end

endmodule

// File: tb/tb_mips32_program_loader.sv
// Directed self-checking bench for mips32_program_loader. A queue of expected
// memory writes is built from the byte stream with plain arithmetic and a
// per-cycle monitor checks every write against it.
module tb_mips32_program_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 9;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_ready, mem_we, cpu_hold, busy, done, error;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stream [8] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
    logic [39:0] exp_q [$];
    logic [7:0]  log_a [$];
    logic [31:0] log_d [$];
    logic [39:0] e;

    mips32_program_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_sum(input int cnt);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 4 * cnt; i++) s = s + stream[i % 8];
        return s;
    endfunction

    function automatic logic [31:0] model_word(input int i);
        return {stream[(4*i) % 8], stream[(4*i+1) % 8], stream[(4*i+2) % 8], stream[(4*i+3) % 8]};
    endfunction

    // Per-cycle monitor: every write must match the next expected one.
    always @(negedge clk) begin
        if (!reset) begin
            check("hold_eq_busy", 64'(cpu_hold), 64'(busy));
            if (mem_we) begin
                check("we_while_ready", 64'(in_ready), 64'(0));
                log_a.push_back(mem_addr);
                log_d.push_back(mem_wdata);
                check("write_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e[39:32]));
                    check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_error"}, 64'(error), 64'(0));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  n;
        bit  acc;
        if (gaps) begin
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 20) begin
                check("byte_accept_timeout", 64'(0), 64'(1));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] base, input int cnt);
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = base;
        word_count = CNT_W'(cnt);
        @(posedge clk);
        #1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        check("start_error_clear", 64'(error), 64'(0));
        check("start_busy", 64'(busy), 64'(1));
    endtask

    task automatic run_load(input logic [7:0] base, input int cnt, input logic [7:0] cks,
                            input bit gaps, input int busy_start_at);
        logic exp_err;
        exp_err = (cks != model_sum(cnt));
        log_a.delete();
        log_d.delete();
        for (int i = 0; i < cnt; i++) exp_q.push_back({8'(base + 8'(i)), model_word(i)});
        do_start(base, cnt);
        for (int k = 0; k < 4 * cnt; k++) begin
            send_byte(stream[k % 8], gaps);
            if (k == busy_start_at) begin
                start      = 1'b1;
                base_addr  = 8'h40;
                word_count = CNT_W'(1);
                @(posedge clk);
                #1;
                start = 1'b0;
                check("busy_start_ignored", 64'(busy), 64'(1));
            end
        end
        send_byte(cks, gaps);
        check("done_pulse", 64'(done), 64'(1));
        check("error_level", 64'(error), 64'(exp_err));
        check("writes_drained", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_hold", 64'(cpu_hold), 64'(0));
        check("error_held", 64'(error), 64'(exp_err));
    endtask

    task automatic check_log(input string tag, input int idx, input logic [7:0] a, input logic [31:0] d);
        check({tag, "_logged"}, 64'(log_a.size() > idx), 64'(1));
        if (log_a.size() > idx) begin
            check({tag, "_addr"}, 64'(log_a[idx]), 64'(a));
            check({tag, "_data"}, 64'(log_d[idx]), 64'(d));
        end
    endtask

    initial begin
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Hand-computed pins on the model itself.
        check("model_sum2", 64'(model_sum(2)), 64'(8'hEB));
        check("model_sum1", 64'(model_sum(1)), 64'(8'h91));
        check("model_word0", 64'(model_word(0)), 64'(32'h8C010004));
        check("model_word1", 64'(model_word(1)), 64'(32'h00221820));

        // Basic load.
        run_load(8'h10, 2, model_sum(2), 1'b0, -1);
        check_log("basic0", 0, 8'h10, 32'h8C010004);
        check_log("basic1", 1, 8'h11, 32'h00221820);

        // Bad checksum: writes still happen, error latched.
        run_load(8'h10, 2, 8'h00, 1'b0, -1);
        check("bad_err_level", 64'(error), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        check("bad_err_still", 64'(error), 64'(1));

        // Address wrap (start also clears the error).
        run_load(8'hFF, 2, model_sum(2), 1'b0, -1);
        check_log("wrap0", 0, 8'hFF, 32'h8C010004);
        check_log("wrap1", 1, 8'h00, 32'h00221820);

        // Zero-length load.
        run_load(8'h00, 0, 8'h00, 1'b0, -1);
        check("zero_no_writes", 64'(log_a.size()), 64'(0));

        // Backpressure gaps.
        run_load(8'h10, 2, model_sum(2), 1'b1, -1);
        check_log("gap1", 1, 8'h11, 32'h00221820);

        // Start while busy is ignored.
        run_load(8'h10, 2, model_sum(2), 1'b0, 1);
        check_log("sbusy0", 0, 8'h10, 32'h8C010004);
        check_log("sbusy1", 1, 8'h11, 32'h00221820);

        // Reset mid-load, after two bytes of the second word.
        log_a.delete();
        log_d.delete();
        exp_q.push_back({8'h30, model_word(0)});
        exp_q.push_back({8'h31, model_word(1)});
        do_start(8'h30, 2);
        for (int k = 0; k < 6; k++) send_byte(stream[k], 1'b0);
        check("prereset_pending", 64'(exp_q.size()), 64'(1));
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_load(8'h20, 1, model_sum(1), 1'b0, -1);
        check_log("after_reset", 0, 8'h20, 32'h8C010004);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
